// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index width and hazard-control FSM states.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } hcu_state_t;

  localparam regbits_t REG_ZERO = '0;

  function automatic logic reg_match(input regbits_t a, input regbits_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/hazard_control_unit_hit_latch.sv
// Holds a single-cycle cache hit pulse until the pipeline advances.
module hit_latch (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  input  logic clr,
  output logic held
);

  // Clear wins: a pulse arriving on the advancing cycle is consumed by that tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        held <= 1'b0;
    else if (clr)   held <= 1'b0;
    else if (pulse) held <= 1'b1;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline advance/stall/bubble/flush control with sticky halt and saturating perf counters.
//   state  | meaning
//   RUN    | advanced last cycle
//   WAIT   | waiting on outstanding cache hits
//   HALTED | halt retired; pipeline frozen until reset
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             MEM_dREN,
  input  logic             MEM_dWEN,
  input  logic             MEM_halt,
  input  regbits_t         ID_rs,
  input  regbits_t         ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_MemToReg,
  input  regbits_t         EX_RegDst,
  input  logic             EX_branch_taken,
  input  logic             EX_jump,
  output logic             tick,
  output logic             lw_hazard,
  output logic [1:0]       lw_later_hazard,
  output logic             branching,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  hcu_state_t state, state_next;
  logic       ihit_q, dhit_q;
  logic       dreq, running, rs_match, rt_match;

  hit_latch u_ihit (.clk(CLK), .rst(RST), .pulse(ihit), .clr(tick), .held(ihit_q));
  hit_latch u_dhit (.clk(CLK), .rst(RST), .pulse(dhit), .clr(tick), .held(dhit_q));

  assign dreq     = MEM_dREN | MEM_dWEN;
  assign running  = (state != HALTED);
  assign rs_match = reg_match(EX_RegDst, ID_rs);
  assign rt_match = ID_uses_rt & reg_match(EX_RegDst, ID_rt);

  // Nothing advances or flushes while reset is held.
  assign tick      = ~RST & running & (ihit | ihit_q) & (~dreq | dhit | dhit_q);
  assign branching = ~RST & running & (EX_branch_taken | EX_jump);
  assign lw_hazard = ~RST & EX_MemToReg & (EX_RegDst != REG_ZERO)
                     & (rs_match | rt_match) & ~branching;
  assign halt      = (state == HALTED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (!tick) state_next = WAIT;
      WAIT:    if (tick)  state_next = RUN;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
    if (tick && MEM_halt) state_next = HALTED;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lw_later_hazard <= 2'b00;
    end else if (tick) begin
      lw_later_hazard <= lw_hazard ? {rt_match, rs_match} : 2'b00;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (running && !tick && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (tick && lw_hazard && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
